vx_lsu_rsp_gather: RTL and testbench
====================================

// Module: VX_lsu_rsp_gather
// PURPOSE
//  Receiver-side counterpart of the LSU batching issuer. The issuer splits a warp's LSU_MEM_REQS lane requests
//  into DCACHE_NUM_BATCHES batches of DCACHE_NUM_REQS; this block collects the dcache responses back.
//  Responses are keyed by tag {uuid, lsuq_idx, batch_sel}. The block merges them per LSU queue entry and emits one
//  full-warp response once every active lane has returned. It sits between the dcache core response bus and LSU commit.
// PARAMETERS
//  NUM_LANES   4   lanes per warp request (LSU_MEM_REQS)
//  NUM_REQS    2   dcache response ports per beat (DCACHE_NUM_REQS)
//  QUEUE_SIZE  8   LSU queue entries; lsuq_idx width QW = CLOG2(QUEUE_SIZE)
//  WORD_SIZE   4   bytes per lane word; DW = 8*WORD_SIZE
//  UUID_BITS   44  uuid width, passed through; UW = UP(UUID_BITS)
//  derived: NB = ceil(NUM_LANES/NUM_REQS); BW = UP(CLOG2(NB)); TAG_W = UW+QW+BW (tag = {uuid,idx,batch})
// PORTS
//  clk          in   1               clock; only clock, all state on rising edge
//  reset        in   1               synchronous, active-high
//  alloc_valid  in   1               issuer opens a queue entry (no ready; always accepted)
//  alloc_idx    in   QW              entry index
//  alloc_mask   in   NUM_LANES       active lanes expected back
//  rsp_valid    in   1               dcache response beat valid
//  rsp_mask     in   NUM_REQS        which response ports carry data
//  rsp_data     in   NUM_REQS*DW     per-port read data
//  rsp_tag      in   TAG_W           {uuid, lsuq_idx, batch_sel}
//  rsp_ready    out  1               beat accepted when rsp_valid&&rsp_ready
//  out_valid    out  1               gathered warp response valid
//  out_idx      out  QW              completed entry index
//  out_uuid     out  UW              uuid of completing beat
//  out_mask     out  NUM_LANES       alloc_mask of the entry
//  out_data     out  NUM_LANES*DW    per-lane data; lanes not in mask = 0
//  out_ready    in   1               consumer accepts
// BEHAVIOUR
//  Reset: pending[*]=0, lane data=0, out_valid=0, out_* = 0. rsp_ready=1 from the first cycle after reset.
//  Reset mid-operation discards all entries and any held output.
//  State per entry: pending[NUM_LANES], data[NUM_LANES]. Entry idle iff pending==0.
//  Alloc: pending[idx]<=alloc_mask, mask[idx]<=alloc_mask, data[idx]<=0.
//    Alloc of a non-idle entry is illegal (assertion).
//    alloc_mask==0: entry stays idle and no output is produced.
//  rsp_ready = !out_valid || out_ready. Single registered output slot, so a stalled output back-pressures all beats.
//  Accepted beat, for each i<NUM_REQS with rsp_mask[i]: lane L = batch_sel*NUM_REQS+i.
//    If L<NUM_LANES, data[idx][L]<=rsp_data[i] and pending bit L is cleared. L>=NUM_LANES is ignored.
//    Partial beats are legal; a batch may return over several beats in any order, and batches may arrive in any order.
//    A beat hitting a non-pending lane is illegal (assertion) and must not change state.
//    A beat to an idle entry (e.g. after reset) is accepted and dropped.
//  Completion: the beat whose update makes pending==0 loads the output register next edge.
//    out_data is the merged data including this beat; out_uuid comes from this beat's tag.
//    Latency: completing beat accepted at cycle N gives out_valid=1 at N+1.
//  Output held stable while out_valid && !out_ready; it clears on handshake unless a new completion loads the same edge.
//  Same-cycle alloc and accepted beat: permitted to different entries. Same entry is illegal (assertion).
//  Same-cycle completion and out handshake: the new result replaces the old (back-to-back, one per cycle).
// TESTING
//  T1 alloc idx=3 mask=4'b1111; beats batch0 mask=11 data{A,B}, batch1 mask=11 data{C,D}
//     -> one out: idx=3, mask=1111, data={D,C,B,A}, one cycle after 2nd beat.
//  T2 batch1 before batch0, batch0 split across two single-port beats -> same merged result, emitted after the last beat only.
//  T3 alloc mask=4'b0101 -> beats mask=01 per batch complete it; lanes 1,3 data=0.
//  T4 hold out_ready=0 with entry 2 complete -> rsp_ready=0, out stable; release -> handshake, then entry 5 completes next cycle.
//  T5 interleave entries 0 and 7 beats -> both emitted in completion order, no data crossover.
//  T6 reset after first batch of entry 4 -> out_valid=0; late batch1 beat accepted, no output; fresh alloc of 4 works.

Source files
------------

// File: rtl/vx_lsu_rsp_gather.sv
// -----------------------------------------------------------------------------
// vx_lsu_rsp_gather
// Collects dcache core responses for batched LSU requests and merges them per
// LSU queue entry. Each entry records which lanes are still outstanding; once
// every active lane of an entry has returned, one full-warp response is
// presented on a single registered output slot.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   alloc_*       issuer opens queue entry alloc_idx expecting alloc_mask lanes
//   rsp_*         dcache response beat; rsp_tag = {uuid, lsuq_idx, batch_sel}
//   out_*         gathered warp response (valid/ready handshake)
//
// Beat lane mapping: port i of a beat with batch b lands on lane b*NUM_REQS+i.
// Lanes beyond NUM_LANES (ragged last batch) are dropped.
// -----------------------------------------------------------------------------
module vx_lsu_rsp_gather #(
    parameter int NUM_LANES  = 4,
    parameter int NUM_REQS   = 2,
    parameter int QUEUE_SIZE = 8,
    parameter int WORD_SIZE  = 4,
    parameter int UUID_BITS  = 44,
    parameter int QW    = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1,
    parameter int DW    = 8 * WORD_SIZE,
    parameter int UW    = (UUID_BITS > 0) ? UUID_BITS : 1,
    parameter int NB    = (NUM_LANES + NUM_REQS - 1) / NUM_REQS,
    parameter int BW    = (NB > 1) ? $clog2(NB) : 1,
    parameter int TAG_W = UW + QW + BW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_valid,
    input  logic [QW-1:0]             alloc_idx,
    input  logic [NUM_LANES-1:0]      alloc_mask,
    input  logic                      rsp_valid,
    input  logic [NUM_REQS-1:0]       rsp_mask,
    input  logic [NUM_REQS*DW-1:0]    rsp_data,
    input  logic [TAG_W-1:0]          rsp_tag,
    output logic                      rsp_ready,
    output logic                      out_valid,
    output logic [QW-1:0]             out_idx,
    output logic [UW-1:0]             out_uuid,
    output logic [NUM_LANES-1:0]      out_mask,
    output logic [NUM_LANES*DW-1:0]   out_data,
    input  logic                      out_ready
);

    logic [NUM_LANES-1:0] pending_q [QUEUE_SIZE];
    logic [NUM_LANES-1:0] mask_q    [QUEUE_SIZE];
    logic [DW-1:0]        data_q    [QUEUE_SIZE][NUM_LANES];

    logic [BW-1:0]          rsp_batch;
    logic [QW-1:0]          rsp_idx;
    logic [UW-1:0]          rsp_uuid;
    logic                   rsp_fire;
    logic [NUM_LANES-1:0]   hit;
    logic [DW-1:0]          beat_data [NUM_LANES];
    logic [NUM_LANES-1:0]   cur_pending;
    logic                   entry_live;
    logic                   beat_bad;
    logic                   beat_upd;
    logic                   complete;
    logic [NUM_LANES*DW-1:0] merged;

    assign rsp_batch = rsp_tag[BW-1:0];
    assign rsp_idx   = rsp_tag[BW +: QW];
    assign rsp_uuid  = rsp_tag[TAG_W-1 -: UW];

    // Single output slot: a stalled result blocks all further beats.
    assign rsp_ready = !out_valid || out_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    assign cur_pending = pending_q[rsp_idx];
    assign entry_live  = (cur_pending != '0);

    always_comb begin
        hit = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            beat_data[l] = '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (rsp_mask[i] && (int'(rsp_batch) * NUM_REQS + i == l)) begin
                    hit[l]       = 1'b1;
                    beat_data[l] = rsp_data[i*DW +: DW];
                end
            end
        end
    end

    // A beat touching an already-returned lane is discarded as a whole so a
    // protocol error cannot corrupt a partially gathered entry. Beats to idle
    // entries fall out the same way (nothing is pending).
    assign beat_bad = rsp_fire && entry_live && ((hit & ~cur_pending) != '0);
    assign beat_upd = rsp_fire && entry_live && !beat_bad;
    assign complete = beat_upd && (hit != '0) && ((cur_pending & ~hit) == '0);

    always_comb begin
        merged = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            merged[l*DW +: DW] = hit[l] ? beat_data[l] : data_q[rsp_idx][l];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < QUEUE_SIZE; q++) begin
                pending_q[q] <= '0;
                mask_q[q]    <= '0;
                for (int l = 0; l < NUM_LANES; l++) begin
                    data_q[q][l] <= '0;
                end
            end
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_uuid  <= '0;
            out_mask  <= '0;
            out_data  <= '0;
        end else begin
            if (beat_upd) begin
                pending_q[rsp_idx] <= cur_pending & ~hit;
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (hit[l]) begin
                        data_q[rsp_idx][l] <= beat_data[l];
                    end
                end
            end

            if (alloc_valid) begin
                pending_q[alloc_idx] <= alloc_mask;
                mask_q[alloc_idx]    <= alloc_mask;
                for (int l = 0; l < NUM_LANES; l++) begin
                    data_q[alloc_idx][l] <= '0;
                end
            end

            // A completion on the handshake edge replaces the consumed result.
            if (complete) begin
                out_valid <= 1'b1;
                out_idx   <= rsp_idx;
                out_uuid  <= rsp_uuid;
                out_mask  <= mask_q[rsp_idx];
                out_data  <= merged;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    logic alloc_busy;
    logic alloc_clash;

    assign alloc_busy  = alloc_valid && (pending_q[alloc_idx] != '0);
    assign alloc_clash = alloc_valid && rsp_fire && (alloc_idx == rsp_idx);

    a_alloc_busy:  assert property (@(posedge clk) disable iff (reset) !alloc_busy);
    a_beat_bad:    assert property (@(posedge clk) disable iff (reset) !beat_bad);
    a_alloc_clash: assert property (@(posedge clk) disable iff (reset) !alloc_clash);

endmodule

// File: tb/tb_vx_lsu_rsp_gather.sv
// -----------------------------------------------------------------------------
// tb_vx_lsu_rsp_gather
// Directed bench for vx_lsu_rsp_gather: gathering in and out of order, partial
// masks, output back-pressure, interleaved entries and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_vx_lsu_rsp_gather;

    localparam int QW = 3;
    localparam int DW = 32;
    localparam int UW = 44;
    localparam int TAG_W = UW + QW + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            alloc_valid;
    logic [QW-1:0]   alloc_idx;
    logic [3:0]      alloc_mask;
    logic            rsp_valid;
    logic [1:0]      rsp_mask;
    logic [2*DW-1:0] rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic            rsp_ready;
    logic            out_valid;
    logic [QW-1:0]   out_idx;
    logic [UW-1:0]   out_uuid;
    logic [3:0]      out_mask;
    logic [4*DW-1:0] out_data;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    vx_lsu_rsp_gather dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .alloc_mask  (alloc_mask),
        .rsp_valid   (rsp_valid),
        .rsp_mask    (rsp_mask),
        .rsp_data    (rsp_data),
        .rsp_tag     (rsp_tag),
        .rsp_ready   (rsp_ready),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_uuid    (out_uuid),
        .out_mask    (out_mask),
        .out_data    (out_data),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [2:0] idx, input logic [3:0] m);
        alloc_valid = 1'b1;
        alloc_idx   = idx;
        alloc_mask  = m;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic set_beat(input logic [2:0] idx, input logic b, input logic [1:0] m,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [43:0] uuid);
        rsp_valid = 1'b1;
        rsp_mask  = m;
        rsp_data  = {d1, d0};
        rsp_tag   = {uuid, idx, b};
    endtask

    task automatic beat(input logic [2:0] idx, input logic b, input logic [1:0] m,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [43:0] uuid);
        set_beat(idx, b, m, d0, d1, uuid);
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [2:0] idx, input logic [3:0] m,
                             input logic [43:0] uuid, input logic [127:0] d);
        check({tag, "_valid"}, 128'(out_valid), 128'(1));
        check({tag, "_idx"},   128'(out_idx), 128'(idx));
        check({tag, "_mask"},  128'(out_mask), 128'(m));
        check({tag, "_uuid"},  128'(out_uuid), 128'(uuid));
        check({tag, "_data"},  out_data, d);
    endtask

    localparam logic [31:0] A = 32'hAAAA0001;
    localparam logic [31:0] B = 32'hBBBB0002;
    localparam logic [31:0] C = 32'hCCCC0003;
    localparam logic [31:0] D = 32'hDDDD0004;
    localparam logic [31:0] E = 32'hEEEE0005;
    localparam logic [31:0] F = 32'hFFFF0006;
    localparam logic [31:0] J = 32'h5A5A5A5A;

    initial begin
        reset = 1'b1;
        alloc_valid = 1'b0; alloc_idx = '0; alloc_mask = '0;
        rsp_valid = 1'b0; rsp_mask = '0; rsp_data = '0; rsp_tag = '0;
        out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_idx",   128'(out_idx), 128'(0));
        check("rst_out_data",  out_data, 128'(0));
        check("rst_rsp_ready", 128'(rsp_ready), 128'(1));

        // T1: in-order batches
        alloc(3'd3, 4'b1111);
        beat(3'd3, 1'b0, 2'b11, A, B, 44'h111);
        check("t1_early", 128'(out_valid), 128'(0));
        beat(3'd3, 1'b1, 2'b11, C, D, 44'h112);
        check_out("t1", 3'd3, 4'b1111, 44'h112, {D, C, B, A});
        tick();
        check("t1_clear", 128'(out_valid), 128'(0));

        // T2: batch1 first, batch0 split into single-port beats
        alloc(3'd6, 4'b1111);
        beat(3'd6, 1'b1, 2'b11, C, D, 44'h221);
        check("t2_b1", 128'(out_valid), 128'(0));
        beat(3'd6, 1'b0, 2'b01, A, J, 44'h222);
        check("t2_p0", 128'(out_valid), 128'(0));
        beat(3'd6, 1'b0, 2'b10, J, B, 44'h223);
        check_out("t2", 3'd6, 4'b1111, 44'h223, {D, C, B, A});
        tick();

        // T3: sparse mask, plus an empty alloc that must never complete
        alloc(3'd2, 4'b0000);
        tick();
        check("t3_empty", 128'(out_valid), 128'(0));
        alloc(3'd1, 4'b0101);
        beat(3'd1, 1'b0, 2'b01, E, J, 44'h331);
        check("t3_early", 128'(out_valid), 128'(0));
        beat(3'd1, 1'b1, 2'b01, F, J, 44'h332);
        check_out("t3", 3'd1, 4'b0101, 44'h332, {32'h0, F, 32'h0, E});
        tick();

        // T4: back-pressure, then release with a completion on the same edge
        alloc(3'd2, 4'b1111);
        alloc(3'd5, 4'b1111);
        beat(3'd5, 1'b0, 2'b11, E, F, 44'h441);
        beat(3'd2, 1'b0, 2'b11, A, B, 44'h442);
        out_ready = 1'b0;
        beat(3'd2, 1'b1, 2'b11, C, D, 44'h443);
        check_out("t4_done", 3'd2, 4'b1111, 44'h443, {D, C, B, A});
        check("t4_ready_lo", 128'(rsp_ready), 128'(0));
        set_beat(3'd5, 1'b1, 2'b11, A, C, 44'h444);
        tick();
        check_out("t4_hold", 3'd2, 4'b1111, 44'h443, {D, C, B, A});
        check("t4_ready_lo2", 128'(rsp_ready), 128'(0));
        out_ready = 1'b1;
        #1;
        check("t4_ready_hi", 128'(rsp_ready), 128'(1));
        tick();
        rsp_valid = 1'b0;
        check_out("t4_next", 3'd5, 4'b1111, 44'h444, {C, A, F, E});
        tick();
        check("t4_clear", 128'(out_valid), 128'(0));

        // T5: interleaved entries 0 and 7
        alloc(3'd0, 4'b1111);
        alloc(3'd7, 4'b1111);
        beat(3'd0, 1'b0, 2'b11, A, B, 44'h551);
        beat(3'd7, 1'b1, 2'b11, E, F, 44'h552);
        check("t5_none", 128'(out_valid), 128'(0));
        beat(3'd7, 1'b0, 2'b11, C, D, 44'h553);
        check_out("t5_e7", 3'd7, 4'b1111, 44'h553, {F, E, D, C});
        beat(3'd0, 1'b1, 2'b11, E, F, 44'h554);
        check_out("t5_e0", 3'd0, 4'b1111, 44'h554, {F, E, B, A});
        tick();
        check("t5_clear", 128'(out_valid), 128'(0));

        // T6: reset mid-gather discards the entry
        alloc(3'd4, 4'b1111);
        beat(3'd4, 1'b0, 2'b11, A, B, 44'h661);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_valid", 128'(out_valid), 128'(0));
        check("t6_rst_ready", 128'(rsp_ready), 128'(1));
        beat(3'd4, 1'b1, 2'b11, C, D, 44'h662);
        check("t6_late", 128'(out_valid), 128'(0));
        tick();
        check("t6_late2", 128'(out_valid), 128'(0));
        alloc(3'd4, 4'b0011);
        beat(3'd4, 1'b0, 2'b11, E, F, 44'h663);
        check_out("t6_fresh", 3'd4, 4'b0011, 44'h663, {32'h0, 32'h0, F, E});
        tick();
        check("t6_clear", 128'(out_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
